// File: rtl/sysbus_mem_arbiter_if.sv
// Bus bundle between the core/GEMM requesters, the arbiter and the shared data-memory port.
interface sysbus_mem_arbiter_if #(
  parameter int unsigned A_WID  = 32,
  parameter int unsigned C_DWID = 32,
  parameter int unsigned G_DWID = 128
);
  logic              core_req;
  logic              core_we;
  logic [3:0]        core_mask;
  logic [A_WID-1:0]  core_addr;
  logic [C_DWID-1:0] core_wdata;
  logic              core_gnt;
  logic              core_rvalid;
  logic [C_DWID-1:0] core_rdata;

  logic              gemm_req;
  logic              gemm_we;
  logic [A_WID-1:0]  gemm_addr;
  logic [G_DWID-1:0] gemm_wdata;
  logic              gemm_gnt;
  logic              gemm_rvalid;
  logic [G_DWID-1:0] gemm_rdata;

  logic              mem_en;
  logic              mem_we;
  logic              mem_sel;
  logic [3:0]        mem_mask;
  logic [A_WID-1:0]  mem_addr;
  logic [G_DWID-1:0] mem_wdata;
  logic [G_DWID-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_mask, core_addr, core_wdata,
    input  gemm_req, gemm_we, gemm_addr, gemm_wdata,
    input  mem_rdata,
    output core_gnt, core_rvalid, core_rdata,
    output gemm_gnt, gemm_rvalid, gemm_rdata,
    output mem_en, mem_we, mem_sel, mem_mask, mem_addr, mem_wdata
  );

  modport master (
    output core_req, core_we, core_mask, core_addr, core_wdata,
    output gemm_req, gemm_we, gemm_addr, gemm_wdata,
    output mem_rdata,
    input  core_gnt, core_rvalid, core_rdata,
    input  gemm_gnt, gemm_rvalid, gemm_rdata,
    input  mem_en, mem_we, mem_sel, mem_mask, mem_addr, mem_wdata
  );
endinterface

// File: rtl/sysbus_mem_arbiter.sv
// Core / GEMM arbiter for the shared data-memory port; GEMM bursts are capped at MAX_BURST
// consecutive grants while the core is waiting.
module sysbus_mem_arbiter #(
  parameter int unsigned A_WID     = 32,
  parameter int unsigned C_DWID    = 32,
  parameter int unsigned G_DWID    = 128,
  parameter int unsigned MAX_BURST = 16
) (
  input logic                clk,
  input logic                rst_n,
  sysbus_mem_arbiter_if.slave bus
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BMAX = CW'(MAX_BURST);

  typedef enum logic [1:0] {S_IDLE, S_CORE, S_GEMM} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] burst_q, burst_d;
  logic          core_rvalid_q, gemm_rvalid_q;
  logic          core_win, gemm_win;

  always_comb begin
    core_win = 1'b0;
    gemm_win = 1'b0;
    if (rst_n) begin
      if (bus.core_req && bus.gemm_req) begin
        unique case (state_q)
          S_IDLE:  core_win = 1'b1;
          S_CORE:  gemm_win = 1'b1;
          default: begin
            if (burst_q == BMAX) core_win = 1'b1;
            else                 gemm_win = 1'b1;
          end
        endcase
      end else begin
        core_win = bus.core_req;
        gemm_win = bus.gemm_req;
      end
    end
  end

  always_comb begin
    state_d = S_IDLE;
    burst_d = '0;
    if (core_win) begin
      state_d = S_CORE;
    end else if (gemm_win) begin
      state_d = S_GEMM;
      if (state_q != S_GEMM)  burst_d = CW'(1);
      else if (burst_q == BMAX) burst_d = BMAX;
      else                      burst_d = burst_q + CW'(1);
    end
  end

  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_sel   = 1'b0;
    bus.mem_mask  = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (core_win) begin
      bus.mem_we    = bus.core_we;
      bus.mem_mask  = bus.core_mask;
      bus.mem_addr  = bus.core_addr;
      bus.mem_wdata = G_DWID'(bus.core_wdata);
    end else if (gemm_win) begin
      bus.mem_we    = bus.gemm_we;
      bus.mem_sel   = 1'b1;
      bus.mem_mask  = '1;
      bus.mem_addr  = bus.gemm_addr;
      bus.mem_wdata = bus.gemm_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      burst_q       <= '0;
      core_rvalid_q <= 1'b0;
      gemm_rvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      burst_q       <= burst_d;
      core_rvalid_q <= core_win & ~bus.core_we;
      gemm_rvalid_q <= gemm_win & ~bus.gemm_we;
    end
  end

  assign bus.core_gnt    = core_win;
  assign bus.gemm_gnt    = gemm_win;
  assign bus.mem_en      = core_win | gemm_win;
  assign bus.core_rvalid = core_rvalid_q;
  assign bus.gemm_rvalid = gemm_rvalid_q;
  assign bus.core_rdata  = bus.mem_rdata[C_DWID-1:0];
  assign bus.gemm_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_sysbus_mem_arbiter.sv
// Randomised and directed checks of sysbus_mem_arbiter against a grant-rule reference model.
module tb_sysbus_mem_arbiter;
  localparam int unsigned A_WID     = 32;
  localparam int unsigned C_DWID    = 32;
  localparam int unsigned G_DWID    = 128;
  localparam int unsigned MAX_BURST = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sysbus_mem_arbiter_if #(.A_WID(A_WID), .C_DWID(C_DWID), .G_DWID(G_DWID)) bus ();

  sysbus_mem_arbiter #(
    .A_WID(A_WID), .C_DWID(C_DWID), .G_DWID(G_DWID), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: last owner (0 none, 1 core, 2 gemm) and unbounded GEMM streak length.
  int m_last   = 0;
  int m_streak = 0;
  bit m_core_rd = 0;
  bit m_gemm_rd = 0;
  logic [G_DWID-1:0] md;

  logic              obs_cg, obs_gg, obs_en, obs_crv, obs_grv;
  logic [C_DWID-1:0] obs_crd;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_last = 0; m_streak = 0; m_core_rd = 0; m_gemm_rd = 0;
  endtask

  task automatic eval();
    bit cg = 0, gg = 0;
    if (bus.core_req && bus.gemm_req) begin
      if (m_last == 0)                    cg = 1;
      else if (m_last == 1)               gg = 1;
      else if (m_streak >= int'(MAX_BURST)) cg = 1;
      else                                gg = 1;
    end else begin
      cg = bus.core_req;
      gg = bus.gemm_req;
    end
    check("core_gnt", bus.core_gnt, cg);
    check("gemm_gnt", bus.gemm_gnt, gg);
    check("mem_en", bus.mem_en, cg | gg);
    if (cg) begin
      check("c_mem_we", bus.mem_we, bus.core_we);
      check("c_mem_sel", bus.mem_sel, 0);
      check("c_mem_mask", bus.mem_mask, bus.core_mask);
      check("c_mem_addr", bus.mem_addr, bus.core_addr);
      check("c_mem_wdata", bus.mem_wdata, {96'h0, bus.core_wdata});
    end else if (gg) begin
      check("g_mem_we", bus.mem_we, bus.gemm_we);
      check("g_mem_sel", bus.mem_sel, 1);
      check("g_mem_mask", bus.mem_mask, 4'hF);
      check("g_mem_addr", bus.mem_addr, bus.gemm_addr);
      check("g_mem_wdata", bus.mem_wdata, bus.gemm_wdata);
    end else begin
      check("idle_mem_bus", {bus.mem_we, bus.mem_sel, bus.mem_mask, bus.mem_addr}, 0);
      check("idle_mem_wdata", bus.mem_wdata, 0);
    end
    check("core_rvalid", bus.core_rvalid, m_core_rd);
    check("gemm_rvalid", bus.gemm_rvalid, m_gemm_rd);
    if (m_core_rd) check("core_rdata", bus.core_rdata, md[31:0]);
    if (m_gemm_rd) check("gemm_rdata", bus.gemm_rdata, md);
    m_streak  = gg ? ((m_last == 2) ? m_streak + 1 : 1) : 0;
    m_last    = cg ? 1 : (gg ? 2 : 0);
    m_core_rd = cg && !bus.core_we;
    m_gemm_rd = gg && !bus.gemm_we;
  endtask

  // Inputs are set just after a rising edge; this runs the cycle and returns at rising edge + 1.
  task automatic cyc(input logic [G_DWID-1:0] rd);
    bus.mem_rdata = rd;
    md = rd;
    @(negedge clk);
    obs_cg = bus.core_gnt; obs_gg = bus.gemm_gnt; obs_en = bus.mem_en;
    obs_crv = bus.core_rvalid; obs_grv = bus.gemm_rvalid; obs_crd = bus.core_rdata;
    eval();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [G_DWID-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic set_core(input bit req, input bit we, input logic [3:0] mask,
                          input logic [31:0] addr, input logic [31:0] wd);
    bus.core_req = req; bus.core_we = we; bus.core_mask = mask;
    bus.core_addr = addr; bus.core_wdata = wd;
  endtask

  task automatic set_gemm(input bit req, input bit we, input logic [31:0] addr);
    bus.gemm_req = req; bus.gemm_we = we; bus.gemm_addr = addr; bus.gemm_wdata = rnd128();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int gcnt, rcnt, ccnt;
    logic [1:0] seq [19];

    rst_n = 1'b0;
    set_core(1, 0, 4'hF, 32'h0, 32'h0);
    set_gemm(1, 0, 32'h0);
    bus.mem_rdata = '0;
    #12;
    check("rst_gnt", {bus.core_gnt, bus.gemm_gnt, bus.mem_en}, 0);
    check("rst_rvalid", {bus.core_rvalid, bus.gemm_rvalid}, 0);
    set_core(0, 0, 0, 0, 0);
    set_gemm(0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();

    // 1: core read then read data returned one cycle later
    set_core(1, 0, 4'hF, 32'h100, 32'h0);
    cyc(rnd128());
    check("t1_gnt_en", {obs_cg, obs_en}, 2'b11);
    set_core(0, 0, 0, 0, 0);
    cyc({96'h0, 32'hDEADBEEF});
    check("t1_rvalid", obs_crv, 1);
    check("t1_rdata", obs_crd, 32'hDEADBEEF);

    // 2: core byte-masked write never raises rvalid
    set_core(1, 1, 4'b0011, 32'h44, 32'h1234ABCD);
    cyc(rnd128());
    set_core(0, 0, 0, 0, 0);
    cyc(rnd128());
    check("t2_no_rvalid", obs_crv, 0);

    // 3: both held from IDLE
    set_core(1, 0, 4'hF, 32'h200, 0);
    set_gemm(1, 0, 32'h1000);
    for (int i = 0; i < 19; i++) begin
      cyc(rnd128());
      seq[i] = {obs_gg, obs_cg};
    end
    for (int i = 0; i < 19; i++)
      check($sformatf("t3_seq%0d", i), seq[i], (i == 0 || i == 17) ? 2'b01 : 2'b10);
    set_core(0, 0, 0, 0, 0);
    set_gemm(0, 0, 0);
    cyc(rnd128());

    // 4: lone 40-beat GEMM read burst, then core arrives while the count is saturated
    gcnt = 0; rcnt = 0;
    for (int i = 0; i < 41; i++) begin
      if (i < 40) set_gemm(1, 0, 32'h2000 + i);
      else        set_gemm(0, 0, 0);
      cyc(rnd128());
      gcnt += int'(obs_gg);
      rcnt += int'(obs_grv);
    end
    check("t4_gnt_cnt", gcnt, 40);
    check("t4_rvalid_cnt", rcnt, 40);
    for (int i = 0; i < 20; i++) begin
      set_gemm(1, 0, 32'h3000 + i);
      cyc(rnd128());
    end
    set_core(1, 1, 4'hF, 32'h300, 32'h55);
    set_gemm(1, 0, 32'h3100);
    cyc(rnd128());
    check("t4_sat_core_first", obs_cg, 1);
    set_core(0, 0, 0, 0, 0);

    // 5: reset mid GEMM read burst
    for (int i = 0; i < 3; i++) begin
      set_gemm(1, 0, 32'h4000 + i);
      cyc(rnd128());
    end
    set_core(1, 0, 4'hF, 32'h400, 0);
    rst_n = 1'b0;
    #1;
    check("t5_rst_now", {bus.core_gnt, bus.gemm_gnt, bus.mem_en, bus.core_rvalid, bus.gemm_rvalid}, 0);
    model_reset();
    @(posedge clk); #1;
    check("t5_rst_hold", {bus.core_gnt, bus.gemm_gnt, bus.mem_en, bus.gemm_rvalid}, 0);
    rst_n = 1'b1;
    cyc(rnd128());
    check("t5_core_first", {obs_gg, obs_cg}, 2'b01);
    set_core(0, 0, 0, 0, 0);

    // 6: core request withdrawn while GEMM owns the port
    gcnt = 0; ccnt = 0;
    for (int i = 0; i < 6; i++) begin
      set_gemm(1, 1, 32'h5000 + i);
      if (i == 3) set_core(1, 1, 4'hF, 32'h500, 32'h77);
      else        set_core(0, 0, 0, 0, 0);
      cyc(rnd128());
      if (i >= 3) begin
        gcnt += int'(obs_gg);
        ccnt += int'(obs_cg);
      end
    end
    check("t6_no_core_gnt", ccnt, 0);
    check("t6_gemm_cont", gcnt, 3);
    set_gemm(0, 0, 0);
    cyc(rnd128());

    // Random traffic obeying the hold-until-grant protocol, with occasional withdrawals
    for (int i = 0; i < 600; i++) begin
      if (!(bus.core_req && !obs_cg && $urandom_range(7) != 0))
        set_core($urandom_range(2) != 0, $urandom_range(1) != 0, 4'($urandom), $urandom, $urandom);
      if (!(bus.gemm_req && !obs_gg && $urandom_range(7) != 0))
        set_gemm($urandom_range(7) != 0, $urandom_range(1) != 0, $urandom);
      cyc(rnd128());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
